// File: rtl/ram_program_loader.sv
// Instruction RAM loader: parses a big-endian framed program from a byte stream
// (16-bit word count, 32-bit words, XOR checksum byte) into sequential RAM writes.
// Latency: one RAM write cycle after each 4th data byte; >= 5 cycles per word.
// Backpressure: in_ready depends on state only; it drops during WRITE and outside a load.
// Ports:
//   clk, rst              clock, async active-high reset
//   start, abort          control pulses (begin load / terminate active load)
//   in_valid/in_data      host byte stream, accepted when in_valid && in_ready
//   ram_we/addr/wdata     RAM write port, one strobe per assembled word
//   cpu_hold              keeps PC/fetch in reset until a load succeeds
//   done, error           load result flags, held until the next start
//   words_written         words written in the current or last load
module ram_program_loader #(
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 65536,
   parameter int START_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_written
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   // Length bound evaluated at 17 bits so a full 65536-word RAM is representable.
   localparam logic [16:0]           MAX_LEN  = 17'(DEPTH - START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] START    = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                state;
   logic [15:0]           len;
   logic [1:0]            byte_idx;
   logic [7:0]            csum;
   logic [23:0]           shreg;     // first three bytes of the word; the 4th is appended at write time
   logic [ADDR_WIDTH-1:0] addr;

   logic        xfer;
   logic [15:0] len_next;

   assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CHECK);
   assign xfer     = in_valid && in_ready;
   assign len_next = {len[15:8], in_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         len           <= '0;
         byte_idx      <= '0;
         csum          <= '0;
         shreg         <= '0;
         addr          <= '0;
         ram_we        <= 1'b0;
         ram_addr      <= '0;
         ram_wdata     <= '0;
         cpu_hold      <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         words_written <= '0;
      end else begin
         ram_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state         <= S_LEN_HI;
                  done          <= 1'b0;
                  error         <= 1'b0;
                  words_written <= '0;
                  csum          <= '0;
                  cpu_hold      <= 1'b1;
               end
            end
            S_LEN_HI: begin
               if (abort) begin
                  state <= S_ERROR;
                  error <= 1'b1;
               end else if (xfer) begin
                  len[15:8] <= in_data;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (abort) begin
                  state <= S_ERROR;
                  error <= 1'b1;
               end else if (xfer) begin
                  len[7:0] <= in_data;
                  if ({1'b0, len_next} > MAX_LEN) begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end else if (len_next == 16'd0) begin
                     state <= S_CHECK;
                  end else begin
                     state    <= S_DATA;
                     byte_idx <= '0;
                     addr     <= START;
                  end
               end
            end
            S_DATA: begin
               if (abort) begin
                  state <= S_ERROR;
                  error <= 1'b1;
               end else if (xfer) begin
                  shreg    <= {shreg[15:0], in_data};
                  csum     <= csum ^ in_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     ram_we    <= 1'b1;
                     ram_addr  <= addr;
                     ram_wdata <= {shreg, in_data};
                     state     <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               // The strobe is already on the bus this cycle, so the word is
               // committed and counted even when abort arrives now.
               addr          <= addr + ADDR_ONE;
               words_written <= words_written + 16'd1;
               byte_idx      <= '0;
               if (abort) begin
                  state <= S_ERROR;
                  error <= 1'b1;
               end else if (words_written + 16'd1 == len) begin
                  state <= S_CHECK;
               end else begin
                  state <= S_DATA;
               end
            end
            S_CHECK: begin
               if (abort) begin
                  state <= S_ERROR;
                  error <= 1'b1;
               end else if (xfer) begin
                  if (in_data == csum) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_program_loader.sv
// Testbench for ram_program_loader: directed frames drive the byte stream while a
// separate monitor checks every RAM write against a queue of expected writes.
module tb_ram_program_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_q[$];

   logic [7:0] frame [11];

   ram_program_loader #(.ADDR_WIDTH(16), .DEPTH(16), .START_ADDR(0)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error),
      .words_written(words_written)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every cycle with ram_we high must match the oldest expected write.
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr, ram_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("write_addr", 32'(ram_addr), 32'(e.a));
            chk("write_data", ram_wdata, e.d);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offers one byte and returns one step after the edge on which it transferred.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n = 0;
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got in_ready=%b expected 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic push_good();
      exp_q.push_back({16'h0000, 32'h12345678});
      exp_q.push_back({16'h0001, 32'hDEADBEEF});
   endtask

   task automatic send_frame(input logic [7:0] last, input bit gaps);
      for (int i = 0; i < 10; i++) send_byte(frame[i], gaps);
      send_byte(last, gaps);
   endtask

   task automatic drain(input string name);
      repeat (3) tick();
      chk(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};

      // Reset state
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_words", 32'(words_written), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_in_ready", 32'(in_ready), 32'd0);

      // Good load
      push_good();
      pulse_start();
      chk("start_hold", 32'(cpu_hold), 32'd1);
      chk("start_in_ready", 32'(in_ready), 32'd1);
      send_frame(8'h2A, 1'b0);
      chk("good_done", 32'(done), 32'd1);
      chk("good_error", 32'(error), 32'd0);
      chk("good_hold", 32'(cpu_hold), 32'd0);
      chk("good_words", 32'(words_written), 32'd2);
      chk("good_in_ready", 32'(in_ready), 32'd0);
      drain("good_pending");

      // Bad checksum: writes still happen, CPU stays held
      push_good();
      pulse_start();
      chk("restart_clears_done", 32'(done), 32'd0);
      send_frame(8'h2B, 1'b0);
      chk("bad_error", 32'(error), 32'd1);
      chk("bad_done", 32'(done), 32'd0);
      chk("bad_hold", 32'(cpu_hold), 32'd1);
      chk("bad_words", 32'(words_written), 32'd2);
      drain("bad_pending");

      // Oversize: 17 words into a 16-word RAM
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      chk("over_error", 32'(error), 32'd1);
      chk("over_in_ready", 32'(in_ready), 32'd0);
      chk("over_hold", 32'(cpu_hold), 32'd1);
      drain("over_pending");

      // Exactly 16 words fills the RAM; bytes 0..63 XOR to 0
      for (int w = 0; w < 16; w++)
         exp_q.push_back({16'(w), 8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h10, 1'b0);
      for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
      send_byte(8'h00, 1'b0);
      chk("full_done", 32'(done), 32'd1);
      chk("full_words", 32'(words_written), 32'd16);
      drain("full_pending");

      // Zero length
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_words", 32'(words_written), 32'd0);
      drain("zero_pending");

      // Random valid gaps
      push_good();
      pulse_start();
      send_frame(8'h2A, 1'b1);
      chk("gap_done", 32'(done), 32'd1);
      chk("gap_words", 32'(words_written), 32'd2);
      drain("gap_pending");

      // Abort while the 5th frame byte is offered
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(frame[i], 1'b0);
      in_valid = 1'b1;
      in_data  = frame[4];
      abort    = 1'b1;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_error", 32'(error), 32'd1);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      chk("abort_words", 32'(words_written), 32'd0);
      chk("abort_hold", 32'(cpu_hold), 32'd1);
      drain("abort_pending");

      // Reset after 6 data bytes (one word already written)
      exp_q.push_back({16'h0000, 32'h12345678});
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(frame[i], 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
      chk("mid_rst_words", 32'(words_written), 32'd0);
      chk("mid_rst_wdata", ram_wdata, 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_error", 32'(error), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd0);
      drain("rst_pending");

      // Restart with a start pulse injected during DATA
      push_good();
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(frame[i], 1'b0);
      pulse_start();
      chk("start_in_data_ready", 32'(in_ready), 32'd1);
      for (int i = 4; i < 10; i++) send_byte(frame[i], 1'b0);
      send_byte(8'h2A, 1'b0);
      chk("restart_done", 32'(done), 32'd1);
      chk("restart_words", 32'(words_written), 32'd2);
      drain("restart_pending");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_program_loader.md
Name: ram_program_loader

Overview:
- Writer side of the instruction RAM. The fetch path reads RAM and feeds instructions to the ALU; this block fills that RAM at run time from a byte stream.
- Receives a framed program: 16-bit word count, then 32-bit instructions, then an XOR checksum byte.
- Writes each word to sequential RAM addresses.
- Holds the CPU (PC/fetch) in reset while loading, and releases it only after a good checksum.

Parameters:
ADDR_WIDTH, 16, RAM address width (matches the 16-bit PC).
DEPTH, 65536, number of 32-bit RAM words.
START_ADDR, 0, first RAM address written.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load when idle, done or error
abort  input  1  one-cycle pulse; terminates an active load
in_valid  input  1  host byte valid
in_data  input  8  host byte
in_ready  output  1  loader can accept a byte; a byte transfers when in_valid && in_ready on a clock edge
ram_we  output  1  RAM write strobe, one cycle per word
ram_addr  output  ADDR_WIDTH  RAM write address
ram_wdata  output  32  RAM write data
cpu_hold  output  1  keeps PC/fetch in reset while high
done  output  1  load completed, checksum good
error  output  1  load failed (bad checksum, oversize length, or abort)
words_written  output  16  count of words written in the current or last load

Behaviour:
- Reset values: all outputs 0; state IDLE; internal length, byte index, checksum and shift register cleared. Reset mid-load abandons the load; RAM words already written are not undone.
- in_ready is a function of state only and never depends on in_valid. It is 1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 elsewhere.
- All multi-byte fields are big-endian (MSB byte first).
- IDLE / DONE / ERROR: on start, go to LEN_HI and in the same edge:
  - clear done, error, words_written and checksum;
  - set cpu_hold=1.
  start in any other state is ignored.
- LEN_HI: on a byte transfer, len[15:8]=byte; go to LEN_LO.
- LEN_LO: on a byte transfer, len[7:0]=byte. Compute the bound at 17 bits.
  - If len > DEPTH-START_ADDR, go to ERROR.
  - Else if len==0, go to CHECK.
  - Else go to DATA with byte_idx=0 and addr=START_ADDR.
- DATA: on each byte transfer, shift the byte into the word register (shift left 8), XOR it into the checksum and increment byte_idx. On the 4th byte, go to WRITE.
- WRITE (exactly one cycle, in_ready=0):
  - ram_we=1, ram_addr=addr, ram_wdata=assembled word;
  - next edge: addr++, words_written++, byte_idx=0;
  - if words_written+1==len go to CHECK, else go to DATA.
  Minimum throughput is therefore 5 cycles per word.
- CHECK: on a byte transfer, if byte==checksum go to DONE, else go to ERROR. The checksum byte is not XORed into the checksum.
- DONE: done=1, cpu_hold=0; held until the next start.
- ERROR: error=1, cpu_hold stays 1 so the CPU never runs a partial image; held until the next start.
- abort: in LEN_HI/LEN_LO/DATA/WRITE/CHECK, abort goes to ERROR on the next edge.
  - Priority is abort > byte transfer, so a byte offered that cycle is not consumed and not counted.
  - If abort coincides with a WRITE cycle, that write still occurs.
  - abort in IDLE/DONE/ERROR is ignored.
- ram_addr never wraps: the length check guarantees the last address is START_ADDR+len-1 < DEPTH.
- ram_addr/ram_wdata hold their last value when ram_we=0.
- words_written saturation is not needed (len ≤ 65535 by field width).

Test Plan:
- Good load: start, then bytes 00 02 12 34 56 78 DE AD BE EF 2A. Required:
  - ram_we pulses twice: addr 0 / 0x12345678, then addr 1 / 0xDEADBEEF;
  - done=1, error=0, cpu_hold=0, words_written=2.
- Bad checksum: same frame with final byte 2B. Required: error=1, done=0, cpu_hold=1; both RAM writes still occurred.
- Oversize: DEPTH=16, bytes 00 11. Required: ERROR directly after LEN_LO, no ram_we, in_ready=0.
- Zero length: bytes 00 00 00. Required: done=1, no ram_we, words_written=0.
- Handshake and abort:
  - Random in_valid gaps give identical writes to the good-load case.
  - Assert abort on the cycle byte 5 is offered: error=1, the byte is not accepted (in_ready drops), words_written=0.
- Reset and restart:
  - Assert rst after 6 data bytes: all outputs go to 0 asynchronously, state IDLE.
  - A following start plus the good frame loads correctly.
  - start pulsed while in DATA is ignored.
